// File: rtl/tick_prescaler_pkg.sv
// Shared timing-chain definitions for the LED matrix controller.
// Holds the prescaler FSM state encoding and the default divisors used when
// chaining prescalers (100 us -> 1 ms -> 10 ms).
package tick_prescaler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned DIV_100US_TO_MS = 10;
  localparam int unsigned DIV_MS_TO_10MS  = 10;

endpackage

// File: rtl/tick_prescaler_counter.sv
// tick_counter: CNT_W-wide tick counter with clear, increment and a terminal
// compare against a supplied limit.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-low reset
//   clr      - clear count to 0 (wins over inc)
//   inc      - increment count by 1
//   limit    - terminal value (effective divisor minus one)
//   count    - current count
//   terminal - count == limit
module tick_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == limit);

endmodule

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides input ticks by a runtime-loadable divisor and emits
// a registered one-clock output tick on every DIV-th input tick.
// Cascadable: pulseOut of one instance feeds pulseIn of the next.
// Ports:
//   clk      - system clock, posedge
//   rst      - synchronous active-low reset
//   pulseIn  - input tick
//   start    - arm counting / retrigger while running
//   stop     - abort counting
//   oneShot  - 1: return to idle after the first output tick
//   divLoad  - load divIn into the divisor register (clears count)
//   divIn    - new divisor; 0 behaves as 1
//   pulseOut - output tick, one clock wide, 1 clk after the terminal input tick
//   count    - current tick count, 0..eff-1
//   busy     - registered (state == RUN)
module tick_prescaler
  import tick_prescaler_pkg::*;
#(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned DEFAULT_DIV = DIV_100US_TO_MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulseIn,
  input  logic             start,
  input  logic             stop,
  input  logic             oneShot,
  input  logic             divLoad,
  input  logic [CNT_W-1:0] divIn,
  output logic             pulseOut,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W-1:0] limit;
  logic             terminal;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             tick_next;

  // Divisor 0 is treated as 1, so the terminal count is 0 in both cases.
  assign limit = (divisor == '0) ? '0 : divisor - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      divisor <= CNT_W'(DEFAULT_DIV);
    end else if (!stop && divLoad) begin
      divisor <= divIn;
    end
  end

  tick_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .limit    (limit),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pulseOut <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      pulseOut <= tick_next;
      busy     <= (state_next == ST_RUN);
    end
  end

  // Strict priority chain: each higher-priority control suppresses all lower
  // ones, including the pulseIn of the same cycle.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    tick_next  = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
      cnt_clr    = 1'b1;
    end else if (divLoad) begin
      cnt_clr = 1'b1;
    end else if (start) begin
      state_next = ST_RUN;
      cnt_clr    = 1'b1;
    end else if (state == ST_RUN && pulseIn) begin
      if (terminal) begin
        cnt_clr   = 1'b1;
        tick_next = 1'b1;
        if (oneShot) begin
          state_next = ST_IDLE;
        end
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_prescaler.sv
module tb_tick_prescaler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulseIn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       oneShot = 1'b0;
  logic       divLoad = 1'b0;
  logic [3:0] divIn = 4'd0;
  logic       pulseOut;
  logic [3:0] count;
  logic       busy;

  int errors = 0;
  int checks = 0;

  tick_prescaler #(
    .CNT_W      (4),
    .DEFAULT_DIV(10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulseIn (pulseIn),
    .start   (start),
    .stop    (stop),
    .oneShot (oneShot),
    .divLoad (divLoad),
    .divIn   (divIn),
    .pulseOut(pulseOut),
    .count   (count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: running flag, tick count and divisor as integers.
  bit m_run   = 0;
  int m_cnt   = 0;
  int m_div   = 10;
  bit m_pulse = 0;

  always @(posedge clk) begin
    int eff;
    eff     = (m_div == 0) ? 1 : m_div;
    m_pulse = 0;
    if (!rst) begin
      m_run = 0; m_cnt = 0; m_div = 10;
    end else if (stop) begin
      m_run = 0; m_cnt = 0;
    end else if (divLoad) begin
      m_div = int'(divIn); m_cnt = 0;
    end else if (start) begin
      m_run = 1; m_cnt = 0;
    end else if (m_run && pulseIn) begin
      m_cnt = (m_cnt + 1) % eff;
      if (m_cnt == 0) begin
        m_pulse = 1;
        if (oneShot) m_run = 0;
      end
    end
    #1;
    chk("model_count", 32'(count), 32'(m_cnt));
    chk("model_pulseOut", 32'(pulseOut), 32'(m_pulse));
    chk("model_busy", 32'(busy), 32'(m_run));
  end

  // Apply one cycle of inputs at the falling edge; outputs of that edge are
  // visible at the next falling edge.
  task automatic cyc(input bit p, input bit st, input bit sp, input bit dl, input logic [3:0] di);
    pulseIn = p; start = st; stop = sp; divLoad = dl; divIn = di;
    @(negedge clk);
    pulseIn = 0; start = 0; stop = 0; divLoad = 0;
  endtask

  initial begin
    rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_count", 32'(count), 0);
    chk("reset_pulseOut", 32'(pulseOut), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1;

    // 1: periodic, divide by 10, pulseIn every 5 clk
    oneShot = 0;
    cyc(0, 1, 0, 0, 0);
    chk("t1_busy_after_start", 32'(busy), 1);
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("t1_count", 32'(count), 32'(i % 10));
      chk("t1_pulse", 32'(pulseOut), (i % 10 == 0) ? 1 : 0);
      chk("t1_busy", 32'(busy), 1);
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("t1_pulse_low", 32'(pulseOut), 0);
    end

    // 2: one-shot, divisor 3
    oneShot = 1;
    cyc(0, 0, 0, 1, 4'd3);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t2_count2", 32'(count), 2);
    chk("t2_nopulse", 32'(pulseOut), 0);
    cyc(1, 0, 0, 0, 0);
    chk("t2_pulse", 32'(pulseOut), 1);
    chk("t2_busy_drop", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("t2_ignored_pulse", 32'(pulseOut), 0);
      chk("t2_ignored_count", 32'(count), 0);
    end

    // 3: divisor 0 acts as 1
    oneShot = 0;
    cyc(0, 0, 0, 1, 4'd0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("t3_pulse", 32'(pulseOut), 1);
      chk("t3_count", 32'(count), 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t3_pulse_end", 32'(pulseOut), 0);

    // 4: stop beats a terminal pulseIn; start+stop in idle stays idle
    cyc(0, 0, 0, 1, 4'd10);
    cyc(0, 1, 0, 0, 0);
    repeat (9) cyc(1, 0, 0, 0, 0);
    chk("t4_count9", 32'(count), 9);
    cyc(1, 0, 1, 0, 0);
    chk("t4_pulse", 32'(pulseOut), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_count", 32'(count), 0);
    cyc(0, 1, 1, 0, 0);
    chk("t4_startstop_busy", 32'(busy), 0);

    // 5: divLoad with coincident pulseIn mid-count
    cyc(0, 1, 0, 0, 0);
    repeat (7) cyc(1, 0, 0, 0, 0);
    chk("t5_count7", 32'(count), 7);
    cyc(1, 0, 0, 1, 4'd4);
    chk("t5_count_clr", 32'(count), 0);
    chk("t5_nopulse", 32'(pulseOut), 0);
    chk("t5_busy", 32'(busy), 1);
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("t5_count3", 32'(count), 3);
    chk("t5_nopulse3", 32'(pulseOut), 0);
    cyc(1, 0, 0, 0, 0);
    chk("t5_pulse4", 32'(pulseOut), 1);

    // 6: synchronous reset mid-count restores divisor 10
    cyc(0, 0, 0, 1, 4'd9);
    cyc(0, 1, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 0, 0);
    chk("t6_count6", 32'(count), 6);
    // glitch on rst between edges must not reset anything
    @(posedge clk);
    #2 rst = 0;
    #2 rst = 1;
    @(negedge clk);
    chk("t6_glitch_count", 32'(count), 6);
    chk("t6_glitch_busy", 32'(busy), 1);
    rst = 0;
    cyc(1, 0, 0, 0, 0);
    rst = 1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_pulse", 32'(pulseOut), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("t6_div10_pulse", 32'(pulseOut), (i == 10) ? 1 : 0);
    end

    // Randomized traffic, checked by the reference model every cycle
    for (int i = 0; i < 4000; i++) begin
      int op;
      op = int'($urandom_range(0, 24));
      if ($urandom_range(0, 63) == 0) oneShot = ~oneShot;
      if ($urandom_range(0, 299) == 0) rst = 0;
      pulseIn = 1'($urandom_range(0, 1));
      start   = (op == 0 || op == 3);
      stop    = (op == 1 || op == 3);
      divLoad = (op == 2);
      divIn   = 4'($urandom_range(0, 6));
      @(negedge clk);
      rst = 1;
    end
    pulseIn = 0; start = 0; stop = 0; divLoad = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
